uart_tfifo_gen: RTL

//  Parametrised UART transmit FIFO, next generation of the TX buffer.

---
 rtl/uart_tfifo_gen.sv | 114 +++++++++++
 1 files changed

// File: rtl/uart_tfifo_gen.sv
// uart_tfifo_gen: parametrised UART transmit FIFO with registered flags, sticky status and low-water trigger.
// Optional UART_TFIFO_PEAK_EN adds a registered high-water mark output (peak).
module uart_tfifo_gen #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int PTR_W  = $clog2(DEPTH),
  parameter int CNT_W  = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fifo_reset,
  input  logic              reset_status,
  input  logic              push,
  input  logic [DATA_W-1:0] data_in,
  input  logic              pop,
  output logic [DATA_W-1:0] data_out,
  input  logic [CNT_W-1:0]  tx_trigger,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty,
  output logic              trig,
  output logic              overrun,
  output logic              underrun
`ifdef UART_TFIFO_PEAK_EN
  ,
  output logic [CNT_W-1:0]  peak
`endif
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  top;
  logic [PTR_W-1:0]  bottom;
  logic [CNT_W-1:0]  next_count;
  logic [CNT_W-1:0]  trig_lvl;
  logic              push_ok;
  logic              pop_ok;
  logic              ovr_ev;
  logic              und_ev;

  // Strobe semantics: push and pop are single-cycle requests with no ready
  // return. A push is taken when not full, or when full and a pop frees the
  // head slot in the same cycle; a pop is taken whenever the FIFO is not empty.
  // Refused requests are dropped and recorded in the sticky overrun/underrun.
  assign push_ok = push & (~full | pop);
  assign pop_ok  = pop & ~empty;
  assign ovr_ev  = push & full & ~pop;
  assign und_ev  = pop & empty;

  assign data_out = mem[bottom];
  assign trig_lvl = (tx_trigger > DEPTH_C) ? DEPTH_C : tx_trigger;

  always_comb begin
    next_count = count;
    case ({push_ok, pop_ok})
      2'b10:   next_count = count + CNT_W'(1);
      2'b01:   next_count = count - CNT_W'(1);
      default: next_count = count;
    endcase
  end

  // Storage is intentionally left unreset; data_out is only meaningful when not empty.
  always_ff @(posedge clk) begin
    if (push_ok && !fifo_reset) begin
      mem[top] <= data_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      top      <= '0;
      bottom   <= '0;
      count    <= '0;
      empty    <= 1'b1;
      full     <= 1'b0;
      trig     <= 1'b1;
      overrun  <= 1'b0;
      underrun <= 1'b0;
    end else if (fifo_reset) begin
      top      <= '0;
      bottom   <= '0;
      count    <= '0;
      empty    <= 1'b1;
      full     <= 1'b0;
      trig     <= 1'b1;
      overrun  <= 1'b0;
      underrun <= 1'b0;
    end else begin
      if (push_ok) top <= top + PTR_W'(1);
      if (pop_ok)  bottom <= bottom + PTR_W'(1);
      count    <= next_count;
      empty    <= (next_count == '0);
      full     <= (next_count == DEPTH_C);
      trig     <= (next_count <= trig_lvl);
      // A fresh event in the clearing cycle wins over reset_status.
      overrun  <= (overrun & ~reset_status) | ovr_ev;
      underrun <= (underrun & ~reset_status) | und_ev;
    end
  end

`ifdef UART_TFIFO_PEAK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      peak <= '0;
    end else if (fifo_reset || reset_status) begin
      peak <= '0;
    end else if (next_count > peak) begin
      peak <= next_count;
    end
  end
`endif

endmodule
